// File: rtl/sg_req_splitter_if.sv
// -----------------------------------------------------------------------------
// sg_req_splitter_if
// Bundles the transfer-control, SG-element and request handshake signals of
// sg_req_splitter.
//   slave  : the splitter's view (consumes SG elements, produces requests)
//   master : the surrounding logic's view (SG reader, control, request issue)
// Signals:
//   XFER_START/XFER_LEN   transfer start strobe and total length in words
//   XFER_BUSY/XFER_DONE   transfer status and completion pulse
//   SG_VALID/SG_EMPTY     SG element available / SG source empty (status only)
//   SG_REN                SG element consume strobe
//   SG_ADDR/SG_LEN        SG element byte address and length in words
//   REQ_VALID/REQ_ACK     request handshake
//   REQ_ADDR/REQ_LEN      request byte address and length in words (1..1024)
//   REQ_LAST              request ends the transfer
// -----------------------------------------------------------------------------
interface sg_req_splitter_if;
    logic        XFER_START;
    logic [31:0] XFER_LEN;
    logic        XFER_BUSY;
    logic        XFER_DONE;
    logic        SG_VALID;
    logic        SG_EMPTY;
    logic        SG_REN;
    logic [63:0] SG_ADDR;
    logic [31:0] SG_LEN;
    logic        REQ_VALID;
    logic        REQ_ACK;
    logic [63:0] REQ_ADDR;
    logic [10:0] REQ_LEN;
    logic        REQ_LAST;

    modport slave (
        input  XFER_START, XFER_LEN, SG_VALID, SG_EMPTY, SG_ADDR, SG_LEN, REQ_ACK,
        output XFER_BUSY, XFER_DONE, SG_REN, REQ_VALID, REQ_ADDR, REQ_LEN, REQ_LAST
    );

    modport master (
        output XFER_START, XFER_LEN, SG_VALID, SG_EMPTY, SG_ADDR, SG_LEN, REQ_ACK,
        input  XFER_BUSY, XFER_DONE, SG_REN, REQ_VALID, REQ_ADDR, REQ_LEN, REQ_LAST
    );
endinterface

// File: rtl/sg_req_splitter.sv
// -----------------------------------------------------------------------------
// sg_req_splitter
// Pops {address, length} scatter-gather elements and cuts them into DMA read
// requests that never exceed C_MAX_REQ_WORDS, never cross a 4 KB address
// boundary and never run past the remaining transfer length.
// Ports:
//   CLK  clock
//   RST  asynchronous active-high reset
//   bus  sg_req_splitter_if.slave (transfer control, SG input, request output)
// Parameters:
//   C_MAX_REQ_WORDS  largest request in 32-bit words, power of two, 1..1024
// -----------------------------------------------------------------------------
module sg_req_splitter #(
    parameter int C_MAX_REQ_WORDS = 128
) (
    input  logic              CLK,
    input  logic              RST,
    sg_req_splitter_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SG,
        S_CALC,
        S_ISSUE,
        S_DONE
    } state_t;

    localparam logic [31:0] MAX_WORDS = 32'(C_MAX_REQ_WORDS);

    state_t      state_reg;
    logic [31:0] xfer_rem_reg;   // words left in the transfer
    logic [31:0] elem_rem_reg;   // words left in the current element
    logic [63:0] addr_reg;       // address of the next request
    logic [10:0] chunk_reg;      // size of the request being issued
    logic        busy_reg;
    logic        done_reg;
    logic        req_valid_reg;
    logic        req_last_reg;

    logic [31:0] boundary_words;
    logic [31:0] chunk_next;
    logic [31:0] chunk_ext;

    // Words left before the next 4 KB boundary; an aligned address yields the
    // full 1024 words naturally because the subtrahend is zero.
    assign boundary_words = 32'd1024 - {22'd0, addr_reg[11:2]};
    assign chunk_ext      = {21'd0, chunk_reg};

    // Smallest of the four limits. The boundary term caps the result at 1024,
    // so it always fits the 11-bit request length.
    always_comb begin
        chunk_next = elem_rem_reg;
        if (xfer_rem_reg < chunk_next) begin
            chunk_next = xfer_rem_reg;
        end
        if (MAX_WORDS < chunk_next) begin
            chunk_next = MAX_WORDS;
        end
        if (boundary_words < chunk_next) begin
            chunk_next = boundary_words;
        end
    end

    // The element is consumed in the same cycle it is seen in WAIT_SG; the
    // state moves on at that edge, so the strobe lasts exactly one cycle.
    assign bus.SG_REN    = (state_reg == S_WAIT_SG) & bus.SG_VALID;

    assign bus.XFER_BUSY = busy_reg;
    assign bus.XFER_DONE = done_reg;
    assign bus.REQ_VALID = req_valid_reg;
    assign bus.REQ_ADDR  = addr_reg;
    assign bus.REQ_LEN   = chunk_reg;
    assign bus.REQ_LAST  = req_last_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= S_IDLE;
            xfer_rem_reg  <= 32'd0;
            elem_rem_reg  <= 32'd0;
            addr_reg      <= 64'd0;
            chunk_reg     <= 11'd0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            req_valid_reg <= 1'b0;
            req_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.XFER_START) begin
                        xfer_rem_reg <= bus.XFER_LEN;
                        busy_reg     <= 1'b1;
                        if (bus.XFER_LEN == 32'd0) begin
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            state_reg <= S_WAIT_SG;
                        end
                    end
                end

                S_WAIT_SG: begin
                    if (bus.SG_VALID) begin
                        addr_reg     <= {bus.SG_ADDR[63:2], 2'b00};
                        elem_rem_reg <= bus.SG_LEN;
                        state_reg    <= S_CALC;
                    end
                end

                S_CALC: begin
                    if (elem_rem_reg == 32'd0) begin
                        // Empty element: nothing to issue, fetch the next one.
                        state_reg <= S_WAIT_SG;
                    end else begin
                        chunk_reg     <= chunk_next[10:0];
                        req_last_reg  <= (chunk_next == xfer_rem_reg);
                        req_valid_reg <= 1'b1;
                        state_reg     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (bus.REQ_ACK) begin
                        addr_reg      <= addr_reg + {51'd0, chunk_reg, 2'b00};
                        elem_rem_reg  <= elem_rem_reg - chunk_ext;
                        xfer_rem_reg  <= xfer_rem_reg - chunk_ext;
                        req_valid_reg <= 1'b0;
                        req_last_reg  <= 1'b0;
                        if (req_last_reg) begin
                            // Any element remainder is simply dropped here.
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else if (elem_rem_reg == chunk_ext) begin
                            state_reg <= S_WAIT_SG;
                        end else begin
                            state_reg <= S_CALC;
                        end
                    end
                end

                S_DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // SG_EMPTY is status only, address bits [1:0] are forced to zero and the
    // minimum never exceeds 1024, so these bits carry no information here.
    logic unused_bits;
    assign unused_bits = ^{bus.SG_EMPTY, bus.SG_ADDR[1:0], chunk_next[31:11]};

endmodule

// File: tb/tb_sg_req_splitter.sv
// -----------------------------------------------------------------------------
// tb_sg_req_splitter
// Table of transfers (elements in, expected requests out) applied in a loop,
// plus hand-written sequences for the zero-length transfer and the
// asynchronous reset in mid-transfer. Expected requests go into a queue when a
// transfer is started and are popped as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_sg_req_splitter;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    sg_req_splitter_if bus ();

    sg_req_splitter #(
        .C_MAX_REQ_WORDS (128)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic [31:0]       xfer_len;
        int                stall;
        int                n_elem;
        logic [2:0][63:0]  e_addr;
        logic [2:0][31:0]  e_len;
        int                n_req;
        logic [2:0][63:0]  r_addr;
        logic [2:0][10:0]  r_len;
        logic [2:0]        r_last;
    } case_t;

    typedef struct {
        logic [63:0] addr;
        logic [10:0] len;
        logic        last;
    } req_t;

    localparam int N_CASES = 6;

    case_t cases [N_CASES];
    req_t  sb [$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic new_case(input int ci, input logic [31:0] xl, input int st);
        cases[ci].xfer_len = xl;
        cases[ci].stall    = st;
        cases[ci].n_elem   = 0;
        cases[ci].n_req    = 0;
        cases[ci].e_addr   = '0;
        cases[ci].e_len    = '0;
        cases[ci].r_addr   = '0;
        cases[ci].r_len    = '0;
        cases[ci].r_last   = '0;
    endtask

    task automatic add_elem(input int ci, input logic [63:0] a, input logic [31:0] l);
        cases[ci].e_addr[cases[ci].n_elem] = a;
        cases[ci].e_len[cases[ci].n_elem]  = l;
        cases[ci].n_elem++;
    endtask

    task automatic add_req(input int ci, input logic [63:0] a, input logic [10:0] l, input logic last);
        cases[ci].r_addr[cases[ci].n_req] = a;
        cases[ci].r_len[cases[ci].n_req]  = l;
        cases[ci].r_last[cases[ci].n_req] = last;
        cases[ci].n_req++;
    endtask

    task automatic run_case(input int ci);
        req_t e;
        req_t cap;
        bit   have_cap  = 1'b0;
        bit   done_seen = 1'b0;
        int   ei        = 0;
        int   ren_cnt   = 0;
        int   wait_cnt  = 0;
        int   last_ack  = -10;

        for (int r = 0; r < cases[ci].n_req; r++) begin
            e.addr = cases[ci].r_addr[r];
            e.len  = cases[ci].r_len[r];
            e.last = cases[ci].r_last[r];
            sb.push_back(e);
        end

        @(negedge CLK);
        bus.XFER_START = 1'b1;
        bus.XFER_LEN   = cases[ci].xfer_len;
        bus.SG_VALID   = 1'b0;
        bus.REQ_ACK    = 1'b0;

        for (int it = 0; it < 400 && !done_seen; it++) begin
            @(negedge CLK);
            // START stays high with a bogus length: it must be ignored.
            bus.XFER_LEN = 32'd5;
            if (it == 0) check("busy_after_start", bus.XFER_BUSY, 1);
            if (bus.XFER_DONE) begin
                done_seen      = 1'b1;
                bus.XFER_START = 1'b0;
                bus.SG_VALID   = 1'b0;
                bus.REQ_ACK    = 1'b0;
                check("done_latency", 64'(it), 64'(last_ack + 1));
            end else begin
                if (bus.REQ_VALID) begin
                    if (have_cap) begin
                        check("hold_addr", bus.REQ_ADDR, cap.addr);
                        check("hold_len",  bus.REQ_LEN,  cap.len);
                        check("hold_last", bus.REQ_LAST, cap.last);
                    end else begin
                        cap.addr = bus.REQ_ADDR;
                        cap.len  = bus.REQ_LEN;
                        cap.last = bus.REQ_LAST;
                        have_cap = 1'b1;
                    end
                    if (wait_cnt < cases[ci].stall) begin
                        bus.REQ_ACK = 1'b0;
                        wait_cnt++;
                    end else begin
                        bus.REQ_ACK = 1'b1;
                        wait_cnt    = 0;
                        have_cap    = 1'b0;
                        last_ack    = it;
                        $display("case %0d req addr=0x%0h len=%0d last=%0b",
                                 ci, bus.REQ_ADDR, bus.REQ_LEN, bus.REQ_LAST);
                        if (sb.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL unexpected_req: got addr 0x%0h, want none", bus.REQ_ADDR);
                        end else begin
                            e = sb.pop_front();
                            check("req_addr", bus.REQ_ADDR, e.addr);
                            check("req_len",  bus.REQ_LEN,  e.len);
                            check("req_last", bus.REQ_LAST, e.last);
                        end
                    end
                end else begin
                    // Ack with no valid request must be ignored.
                    bus.REQ_ACK = 1'b1;
                end
                bus.SG_VALID = (ei < cases[ci].n_elem);
                bus.SG_ADDR  = (ei < cases[ci].n_elem) ? cases[ci].e_addr[ei] : 64'hDEAD_BEEF_0000_0000;
                bus.SG_LEN   = (ei < cases[ci].n_elem) ? cases[ci].e_len[ei] : 32'd77;
                #1;
                if (bus.SG_REN) begin
                    ren_cnt++;
                    ei++;
                end
            end
        end

        check("xfer_done_seen", done_seen, 1);
        check("reqs_left", 64'(sb.size()), 0);
        check("sg_ren_count", 64'(ren_cnt), 64'(cases[ci].n_elem));
        sb.delete();
        @(negedge CLK);
        check("busy_after_done", bus.XFER_BUSY, 0);
        check("done_one_cycle",  bus.XFER_DONE, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;

        // 4 KB split
        new_case(0, 200, 0);
        add_elem(0, 64'h1000_0F00, 200);
        add_req(0, 64'h1000_0F00, 64, 0);
        add_req(0, 64'h1000_1000, 128, 0);
        add_req(0, 64'h1000_1200, 8, 1);
        // transfer ends mid-element, remainder dropped
        new_case(1, 150, 0);
        add_elem(1, 64'h2000, 100);
        add_elem(1, 64'h8000, 100);
        add_req(1, 64'h2000, 100, 0);
        add_req(1, 64'h8000, 50, 1);
        // zero-length element skipped
        new_case(2, 16, 0);
        add_elem(2, 64'h0, 0);
        add_elem(2, 64'h3000, 16);
        add_req(2, 64'h3000, 16, 1);
        // back-pressure on both requests, boundary 4 words away
        new_case(3, 40, 5);
        add_elem(3, 64'h4FF0, 40);
        add_req(3, 64'h4FF0, 4, 0);
        add_req(3, 64'h5000, 36, 1);
        // C_MAX_REQ_WORDS limit
        new_case(4, 300, 0);
        add_elem(4, 64'h0, 300);
        add_req(4, 64'h000, 128, 0);
        add_req(4, 64'h200, 128, 0);
        add_req(4, 64'h400, 44, 1);
        // unaligned address bits dropped, 64-bit address wrap
        new_case(5, 7, 1);
        add_elem(5, 64'h5003, 4);
        add_elem(5, 64'hFFFF_FFFF_FFFF_FFF8, 3);
        add_req(5, 64'h5000, 4, 0);
        add_req(5, 64'hFFFF_FFFF_FFFF_FFF8, 2, 0);
        add_req(5, 64'h0, 1, 1);

        RST            = 1'b1;
        bus.XFER_START = 1'b0;
        bus.XFER_LEN   = 32'd0;
        bus.SG_VALID   = 1'b0;
        bus.SG_EMPTY   = 1'b0;
        bus.SG_ADDR    = 64'd0;
        bus.SG_LEN     = 32'd0;
        bus.REQ_ACK    = 1'b0;

        @(negedge CLK);
        @(negedge CLK);
        check("rst_busy",      bus.XFER_BUSY, 0);
        check("rst_done",      bus.XFER_DONE, 0);
        check("rst_req_valid", bus.REQ_VALID, 0);
        check("rst_req_addr",  bus.REQ_ADDR,  0);
        check("rst_req_len",   bus.REQ_LEN,   0);
        check("rst_req_last",  bus.REQ_LAST,  0);
        RST = 1'b0;

        for (int ci = 0; ci < N_CASES; ci++) begin
            run_case(ci);
        end

        // Zero-length transfer: DONE in the cycle after start, nothing else.
        @(negedge CLK);
        bus.XFER_START = 1'b1;
        bus.XFER_LEN   = 32'd0;
        bus.SG_VALID   = 1'b1;
        bus.SG_ADDR    = 64'h6000;
        bus.SG_LEN     = 32'd8;
        @(negedge CLK);
        bus.XFER_START = 1'b0;
        check("zero_done",      bus.XFER_DONE, 1);
        check("zero_busy",      bus.XFER_BUSY, 1);
        check("zero_sg_ren",    bus.SG_REN,    0);
        check("zero_req_valid", bus.REQ_VALID, 0);
        @(negedge CLK);
        check("zero_done_end",  bus.XFER_DONE, 0);
        check("zero_busy_end",  bus.XFER_BUSY, 0);
        check("zero_sg_ren_end", bus.SG_REN,   0);
        $display("zero-length transfer complete");
        bus.SG_VALID = 1'b0;

        // Reset while a request is pending.
        @(negedge CLK);
        bus.XFER_START = 1'b1;
        bus.XFER_LEN   = 32'd200;
        bus.SG_VALID   = 1'b1;
        bus.SG_ADDR    = 64'h1000_0F00;
        bus.SG_LEN     = 32'd200;
        bus.REQ_ACK    = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            bus.XFER_START = 1'b0;
            if (bus.REQ_VALID) found = 1'b1;
        end
        check("rst_mid_reached_issue", found, 1);
        #2;
        RST = 1'b1;
        #1;
        check("rst_mid_req_valid", bus.REQ_VALID, 0);
        check("rst_mid_busy",      bus.XFER_BUSY, 0);
        check("rst_mid_req_len",   bus.REQ_LEN,   0);
        check("rst_mid_sg_ren",    bus.SG_REN,    0);
        @(negedge CLK);
        RST          = 1'b0;
        bus.SG_VALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("rst_mid_no_done", bus.XFER_DONE, 0);
            check("rst_mid_idle",    bus.XFER_BUSY, 0);
        end
        $display("reset mid-transfer complete");

        run_case(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
